// File: rtl/ili9341_spi_display_model.sv
// Display-side responder for the ILI9341 4-wire SPI link: oversamples the pins,
// decodes CASET/PASET/RAMWR and streams RGB565 pixels into a framebuffer write port.
//
// state  | meaning
// IDLE   | after reset, data bytes dropped
// CASET  | data bytes 0..3 load SC/EC
// PASET  | data bytes 0..3 load SP/EP
// RAMWR  | data byte pairs form pixels written through the window
// IGNORE | unsupported command, data bytes dropped
module ili9341_spi_display_model #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_ADDR_W    = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   display_csb,
  input  logic                   spi_clk,
  input  logic                   spi_mosi,
  input  logic                   data_commandb,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_byte,
  output logic                   vram_wr_ena,
  output logic [VRAM_ADDR_W-1:0] vram_wr_addr,
  output logic [15:0]            vram_wr_data
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CASET  = 3'd1;
  localparam logic [2:0] ST_PASET  = 3'd2;
  localparam logic [2:0] ST_RAMWR  = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  localparam logic [15:0] WIDTH_16  = 16'(DISPLAY_WIDTH);
  localparam logic [15:0] HEIGHT_16 = 16'(DISPLAY_HEIGHT);
  localparam logic [VRAM_ADDR_W-1:0] WIDTH_A = VRAM_ADDR_W'(DISPLAY_WIDTH);

  logic csb_s1_q, csb_s1_d, csb_s2_q, csb_s2_d;
  logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
  logic dc_s1_q, dc_s1_d, dc_s2_q, dc_s2_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_dc_q, byte_dc_d;

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        half_q, half_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        wr_ena_q, wr_ena_d;
  logic [VRAM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic                   sclk_rise;
  logic                   pix_in_range;
  logic [VRAM_ADDR_W-1:0] pix_addr;

  // Pin capture, edge detect and byte assembly
  always_comb begin
    csb_s1_d    = display_csb;
    csb_s2_d    = csb_s1_q;
    sclk_s1_d   = spi_clk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    mosi_s1_d   = spi_mosi;
    mosi_s2_d   = mosi_s1_q;
    dc_s1_d     = data_commandb;
    dc_s2_d     = dc_s1_q;
    sclk_rise   = sclk_s2_q & ~sclk_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    byte_d      = byte_q;
    byte_dc_d   = byte_dc_q;
    if (csb_s2_q) begin
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[5:0], mosi_s2_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done_d = 1'b1;
        byte_d      = {shift_q, mosi_s2_q};
        byte_dc_d   = dc_s2_q;
      end
    end
  end

  assign pix_in_range = (col_q < WIDTH_16) && (row_q < HEIGHT_16);
  assign pix_addr     = VRAM_ADDR_W'(row_q) * WIDTH_A + VRAM_ADDR_W'(col_q);

  // Command decode, window registers and pixel walk
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    half_d      = half_q;
    hi_d        = hi_q;
    sc_d        = sc_q;
    ec_d        = ec_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    col_d       = col_q;
    row_d       = row_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    wr_ena_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (byte_done_q) begin
      if (!byte_dc_q) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = byte_q;
        idx_d       = 3'd0;
        half_d      = 1'b0;
        case (byte_q)
          8'h2A: state_d = ST_CASET;
          8'h2B: state_d = ST_PASET;
          8'h2C: begin
            state_d = ST_RAMWR;
            col_d   = sc_q;
            row_d   = sp_q;
          end
          default: state_d = ST_IGNORE;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            if (idx_q < 3'd4) begin
              idx_d = idx_q + 3'd1;
              if (state_q == ST_CASET) begin
                case (idx_q[1:0])
                  2'd0: sc_d[15:8] = byte_q;
                  2'd1: sc_d[7:0]  = byte_q;
                  2'd2: ec_d[15:8] = byte_q;
                  2'd3: ec_d[7:0]  = byte_q;
                endcase
              end else begin
                case (idx_q[1:0])
                  2'd0: sp_d[15:8] = byte_q;
                  2'd1: sp_d[7:0]  = byte_q;
                  2'd2: ep_d[15:8] = byte_q;
                  2'd3: ep_d[7:0]  = byte_q;
                endcase
              end
            end
          end
          ST_RAMWR: begin
            if (!half_q) begin
              hi_d   = byte_q;
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              if (pix_in_range) begin
                wr_ena_d  = 1'b1;
                wr_addr_d = pix_addr;
                wr_data_d = {hi_q, byte_q};
              end
              // SC > EC collapses to a single column since col >= EC always holds
              if (col_q >= ec_q) begin
                col_d = sc_q;
                row_d = (row_q >= ep_q) ? sp_q : row_q + 16'd1;
              end else begin
                col_d = col_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csb_s1_q    <= 1'b1;
      csb_s2_q    <= 1'b1;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      dc_s1_q     <= 1'b0;
      dc_s2_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_done_q <= 1'b0;
      byte_q      <= 8'd0;
      byte_dc_q   <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      half_q      <= 1'b0;
      hi_q        <= 8'd0;
      sc_q        <= 16'd0;
      ec_q        <= WIDTH_16 - 16'd1;
      sp_q        <= 16'd0;
      ep_q        <= HEIGHT_16 - 16'd1;
      col_q       <= 16'd0;
      row_q       <= 16'd0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'd0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 16'd0;
    end else begin
      csb_s1_q    <= csb_s1_d;
      csb_s2_q    <= csb_s2_d;
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      dc_s1_q     <= dc_s1_d;
      dc_s2_q     <= dc_s2_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      byte_q      <= byte_d;
      byte_dc_q   <= byte_dc_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      half_q      <= half_d;
      hi_q        <= hi_d;
      sc_q        <= sc_d;
      ec_q        <= ec_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_byte     = cmd_byte_q;
  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;

endmodule
